round_key_store: RTL and testbench

Parametrised, writable round-key memory with a built-in sequencer that streams keys out over a valid/ready handshake in forward (encrypt) or reverse (decrypt) order. It sits between the key-expansion logic, which loads keys through the write port, and the cipher round datapath, which consumes one key per accepted transfer. Read data is registered, and the stream can be stalled by the consumer or aborted.

---
 rtl/round_key_store_pkg.sv | 15 +
 rtl/round_key_store_key_ram.sv | 36 +++
 rtl/round_key_store.sv | 105 ++++++++++
 tb/tb_round_key_store.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/round_key_store_pkg.sv
// rtl/round_key_store_pkg.sv - shared types and constants for the round-key store
package round_key_store_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 128;
    localparam int DEF_ADDR_W = 4;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

endpackage

// File: rtl/round_key_store_key_ram.sv
// rtl/round_key_store_key_ram.sv - key array, one write port, registered read port
module round_key_store_key_ram
    import round_key_store_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Array is never reset: contents must survive a mid-stream reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Same-edge read of a written address sees the old word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/round_key_store.sv
// rtl/round_key_store.sv - round-key memory with forward/reverse streaming sequencer
module round_key_store
    import round_key_store_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              WrEn,
    input  logic [ADDR_W-1:0] WrAddr,
    input  logic [DATA_W-1:0] WrData,
    input  logic              Start,
    input  logic              Reverse,
    input  logic [ADDR_W-1:0] LastAddr,
    input  logic              Abort,
    output logic              KeyValid,
    input  logic              KeyReady,
    output logic [DATA_W-1:0] KeyData,
    output logic [ADDR_W-1:0] KeyIndex,
    output logic              Busy,
    output logic              Done
);

    state_t            state;
    logic              rev_q;
    logic [ADDR_W-1:0] last_q;

    logic              xfer;
    logic              is_last;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] next_addr;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;

    assign xfer       = KeyValid & KeyReady;
    assign is_last    = (rev_q == DIR_REV) ? (KeyIndex == '0) : (KeyIndex == last_q);
    assign first_addr = (Reverse == DIR_FWD) ? '0 : LastAddr;
    assign next_addr  = (rev_q == DIR_REV) ? (KeyIndex - ADDR_W'(1)) : (KeyIndex + ADDR_W'(1));

    // The read port fetches exactly when KeyIndex advances, so KeyData tracks it.
    always_comb begin
        rd_en   = 1'b0;
        rd_addr = next_addr;
        if (state == ST_IDLE) begin
            rd_addr = first_addr;
            rd_en   = Start;
        end else begin
            rd_en = ~Abort & xfer & ~is_last;
        end
    end

    round_key_store_key_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) key_ram (
        .clk   (Clock),
        .rst   (Reset),
        .we    (WrEn),
        .waddr (WrAddr),
        .wdata (WrData),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (KeyData)
    );

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state    <= ST_IDLE;
            rev_q    <= DIR_FWD;
            last_q   <= '0;
            KeyValid <= 1'b0;
            KeyIndex <= '0;
            Done     <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (state == ST_IDLE) begin
                if (Start) begin
                    state    <= ST_RUN;
                    rev_q    <= Reverse;
                    last_q   <= LastAddr;
                    KeyIndex <= first_addr;
                    KeyValid <= 1'b1;
                end
            end else begin
                // Abort outranks a transfer on the same edge and never raises Done.
                if (Abort) begin
                    state    <= ST_IDLE;
                    KeyValid <= 1'b0;
                end else if (xfer) begin
                    if (is_last) begin
                        state    <= ST_IDLE;
                        KeyValid <= 1'b0;
                        Done     <= 1'b1;
                    end else begin
                        KeyIndex <= next_addr;
                    end
                end
            end
        end
    end

    assign Busy = (state == ST_RUN);

endmodule

// File: tb/tb_round_key_store.sv
// tb/tb_round_key_store.sv - directed self-checking bench for round_key_store
module tb_round_key_store;

    localparam int DW = 128;
    localparam int AW = 4;
    localparam logic [DW-1:0] DEAD = {4{32'hDEADBEEF}};
    localparam logic [DW-1:0] NEW5 = {4{32'hCAFEF00D}};

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          WrEn = 1'b0;
    logic [AW-1:0] WrAddr = '0;
    logic [DW-1:0] WrData = '0;
    logic          Start = 1'b0;
    logic          Reverse = 1'b0;
    logic [AW-1:0] LastAddr = '0;
    logic          Abort = 1'b0;
    logic          KeyValid;
    logic          KeyReady = 1'b0;
    logic [DW-1:0] KeyData;
    logic [AW-1:0] KeyIndex;
    logic          Busy;
    logic          Done;

    int n_vec = 0;
    int n_bad = 0;

    round_key_store #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .WrEn     (WrEn),
        .WrAddr   (WrAddr),
        .WrData   (WrData),
        .Start    (Start),
        .Reverse  (Reverse),
        .LastAddr (LastAddr),
        .Abort    (Abort),
        .KeyValid (KeyValid),
        .KeyReady (KeyReady),
        .KeyData  (KeyData),
        .KeyIndex (KeyIndex),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 Clock = ~Clock;

    function automatic logic [DW-1:0] pat(input int k);
        logic [7:0] b;
        b = 8'(k);
        return {16{b}};
    endfunction

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check_key(input string tag, input int idx, input logic [DW-1:0] data);
        check({tag, " valid"}, DW'(KeyValid), DW'(1));
        check({tag, " index"}, DW'(KeyIndex), DW'(idx));
        check({tag, " data"}, KeyData, data);
        check({tag, " done"}, DW'(Done), DW'(0));
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        check({tag, " valid"}, DW'(KeyValid), DW'(0));
        check({tag, " busy"}, DW'(Busy), DW'(0));
        check({tag, " done"}, DW'(Done), DW'(done_exp));
    endtask

    initial begin
        step();
        check_idle("reset", 1'b0);
        check("reset data", KeyData, '0);
        check("reset index", DW'(KeyIndex), '0);
        Reset = 1'b0;

        for (int k = 0; k < 16; k++) begin
            WrEn = 1'b1; WrAddr = AW'(k); WrData = pat(k);
            step();
        end
        WrEn = 1'b0;

        // forward full stream
        Start = 1'b1; Reverse = 1'b0; LastAddr = 4'd15; KeyReady = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check_key("fwd", i, pat(i));
            check("fwd busy", DW'(Busy), DW'(1));
            step();
        end
        check_idle("fwd end", 1'b1);
        step();
        check_idle("fwd after", 1'b0);

        // reverse with stalls; a Start during RUN must be ignored
        Start = 1'b1; Reverse = 1'b1; LastAddr = 4'd9;
        step();
        Start = 1'b0;
        for (int i = 9; i >= 0; i--) begin
            KeyReady = 1'b0;
            if (i == 9) begin
                Start = 1'b1; Reverse = 1'b0; LastAddr = 4'd3;
            end
            check_key("rev", i, pat(i));
            step();
            Start = 1'b0;
            check_key("rev stall", i, pat(i));
            KeyReady = 1'b1;
            step();
        end
        check_idle("rev end", 1'b1);
        step();
        check_idle("rev after", 1'b0);

        // one-key streams, second one started back-to-back in the Done cycle
        Start = 1'b1; Reverse = 1'b0; LastAddr = 4'd0;
        step();
        Start = 1'b0;
        check_key("one fwd", 0, pat(0));
        step();
        check_idle("one fwd end", 1'b1);
        Start = 1'b1; Reverse = 1'b1; LastAddr = 4'd0;
        step();
        Start = 1'b0;
        check_key("one rev", 0, pat(0));
        step();
        check_idle("one rev end", 1'b1);
        step();

        // writes during a stream
        Start = 1'b1; Reverse = 1'b0; LastAddr = 4'd15;
        step();
        Start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check_key("wr idx3", 3, pat(3));
        KeyReady = 1'b0; WrEn = 1'b1; WrAddr = 4'd4; WrData = DEAD;
        step();
        WrEn = 1'b0; KeyReady = 1'b1;
        check_key("wr idx3 held", 3, pat(3));
        step();
        check_key("wr new4", 4, DEAD);
        WrEn = 1'b1; WrAddr = 4'd5; WrData = NEW5;
        step();
        WrEn = 1'b0;
        check_key("wr old5", 5, pat(5));

        // abort beats a simultaneous transfer
        Abort = 1'b1;
        step();
        Abort = 1'b0;
        check_idle("abort", 1'b0);
        Start = 1'b1; Reverse = 1'b0; LastAddr = 4'd15;
        step();
        Start = 1'b0;
        check_key("restart", 0, pat(0));
        for (int i = 0; i < 5; i++) step();
        check_key("later new5", 5, NEW5);
        step();
        check_key("pre reset", 6, pat(6));

        // asynchronous reset between edges
        Reset = 1'b1;
        #2;
        check_idle("async rst", 1'b0);
        check("async rst data", KeyData, '0);
        check("async rst index", DW'(KeyIndex), '0);
        step();
        Reset = 1'b0;
        step();
        check_idle("post rst", 1'b0);

        Start = 1'b1; Reverse = 1'b1; LastAddr = 4'd5;
        step();
        Start = 1'b0;
        check_key("keep 5", 5, NEW5);
        step();
        check_key("keep 4", 4, DEAD);
        for (int i = 3; i >= 0; i--) begin
            step();
            check_key("keep", i, pat(i));
        end
        step();
        check_idle("keep end", 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
